// File: rtl/reg_file_2r1w_if.sv
// Register-file access bundle: one write port, two operand read ports, one debug read port.
// The master drives addresses, write enable and write data; the slave returns the read data.
interface reg_file_2r1w_if #(
  parameter int DATA_W = 32
);
  logic              WE;
  logic [4:0]        WA;
  logic [DATA_W-1:0] WD;
  logic [4:0]        RA1;
  logic [4:0]        RA2;
  logic [4:0]        DA;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] DD;

  modport master (
    output WE, WA, WD, RA1, RA2, DA,
    input  RD1, RD2, DD
  );

  modport slave (
    input  WE, WA, WD, RA1, RA2, DA,
    output RD1, RD2, DD
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// 32 x DATA_W register file, one write port, combinational RS/RT/debug reads; no backpressure.
// Write lands at the rising edge; define REG_FILE_WR_BYPASS_EN to forward WD to same-cycle reads.
module reg_file_2r1w #(
  parameter int                DATA_W    = 32,
  parameter int                ZERO_REG  = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic            CLK,
  input  logic            RST,
  reg_file_2r1w_if.slave  bus
);

  localparam bit ZR = (ZERO_REG != 0);
`ifdef REG_FILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic              wr_en;
  logic              byp_vld;

  // Writes to $0 are dropped outright when it is hardwired, so regs_q[0] stays zero.
  always_comb begin
    wr_en   = bus.WE && !(ZR && (bus.WA == 5'd0));
    byp_vld = BYP && wr_en && !RST;
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[bus.WA] = bus.WD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (ZR && (i == 0)) ? '0 : RESET_VAL;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read selectors: storage, then optional forward of the in-flight write, then the zero register.
  always_comb begin
    bus.RD1 = regs_q[bus.RA1];
    bus.RD2 = regs_q[bus.RA2];
    bus.DD  = regs_q[bus.DA];
    if (byp_vld && (bus.RA1 == bus.WA)) bus.RD1 = bus.WD;
    if (byp_vld && (bus.RA2 == bus.WA)) bus.RD2 = bus.WD;
    if (byp_vld && (bus.DA  == bus.WA)) bus.DD  = bus.WD;
    if (ZR && (bus.RA1 == 5'd0)) bus.RD1 = '0;
    if (ZR && (bus.RA2 == 5'd0)) bus.RD2 = '0;
    if (ZR && (bus.DA  == 5'd0)) bus.DD  = '0;
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: dut0 has a hardwired $0 and zero reset value, dut1 has an ordinary $0
// and a non-zero reset value; both see identical stimulus.
module tb_reg_file_2r1w;

  localparam logic [31:0] RV1 = 32'hA5A5_5A5A;

  logic CLK;
  logic RST;

  reg_file_2r1w_if #(.DATA_W(32)) bus0 ();
  reg_file_2r1w_if #(.DATA_W(32)) bus1 ();

  assign bus1.WE  = bus0.WE;
  assign bus1.WA  = bus0.WA;
  assign bus1.WD  = bus0.WD;
  assign bus1.RA1 = bus0.RA1;
  assign bus1.RA2 = bus0.RA2;
  assign bus1.DA  = bus0.DA;

  reg_file_2r1w #(.DATA_W(32), .ZERO_REG(1), .RESET_VAL(32'h0000_0000)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0.slave)
  );

  reg_file_2r1w #(.DATA_W(32), .ZERO_REG(0), .RESET_VAL(RV1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus1.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] observe(input int p);
    case (p)
      0:       return bus0.RD1;
      1:       return bus0.RD2;
      2:       return bus0.DD;
      3:       return bus1.RD1;
      4:       return bus1.RD2;
      default: return bus1.DD;
    endcase
  endfunction

  // Expected read of address a from the reference arrays, including same-cycle forwarding.
  function automatic logic [31:0] pred(input int d, input logic [4:0] a);
    logic [31:0] v;
    if (d == 0) v = (a == 5'd0) ? 32'h0 : m0[a];
    else        v = m1[a];
`ifdef REG_FILE_WR_BYPASS_EN
    if (!RST && bus0.WE && (a == bus0.WA) && !((d == 0) && (a == 5'd0))) v = bus0.WD;
`endif
    return v;
  endfunction

  task automatic push(input string nm, input int p, input logic [31:0] e);
    sb_t s;
    s.name = nm;
    s.port = p;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic push_all(input string nm);
    push({nm, "_rd1"}, 0, pred(0, bus0.RA1));
    push({nm, "_rd2"}, 1, pred(0, bus0.RA2));
    push({nm, "_dd"},  2, pred(0, bus0.DA));
    push({nm, "_rd1_z0"}, 3, pred(1, bus0.RA1));
    push({nm, "_rd2_z0"}, 4, pred(1, bus0.RA2));
    push({nm, "_dd_z0"},  5, pred(1, bus0.DA));
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bus0.WE = we;
    bus0.WA = wa;
    bus0.WD = wd;
  endtask

  task automatic set_ra(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da);
    bus0.RA1 = a1;
    bus0.RA2 = a2;
    bus0.DA  = da;
  endtask

  // One rising edge; the reference arrays take the inputs that were stable across it.
  task automatic step();
    @(posedge CLK);
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        m0[i] = 32'h0;
        m1[i] = RV1;
      end
    end else if (bus0.WE) begin
      if (bus0.WA != 5'd0) m0[bus0.WA] = bus0.WD;
      m1[bus0.WA] = bus0.WD;
    end
    #1;
  endtask

  task automatic test_reset();
    sb_t e;
    logic [31:0] got;
    drive(1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 5'd0, 32'h0);
    set_ra(5'd5, 5'd5, 5'd5);
    push("pre_rst_r5", 0, 32'hDEAD_BEEF);
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = observe(e.port); n_tests++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a), 5'(a), 5'(a));
      push("rst_zero", 0, 32'h0);
      push("rst_val", 4, RV1);
      push_all("rst_sweep");
      #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = observe(e.port); n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
      end
    end
  endtask

  task automatic test_write_read();
    sb_t e;
    logic [31:0] got;
    drive(1'b1, 5'd8, 32'h1234_5678);
    step();
    drive(1'b1, 5'd9, 32'hCAFE_F00D);
    step();
    drive(1'b0, 5'd9, 32'h5555_5555);
    set_ra(5'd8, 5'd9, 5'd8);
    push("wr_rd1_r8", 0, 32'h1234_5678);
    push("wr_rd2_r9", 1, 32'hCAFE_F00D);
    push_all("wr_both");
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = observe(e.port); n_tests++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
    end
    set_ra(5'd9, 5'd9, 5'd9);
    push("same_rd1", 0, 32'hCAFE_F00D);
    push("same_rd2", 1, 32'hCAFE_F00D);
    push("same_dd", 2, 32'hCAFE_F00D);
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = observe(e.port); n_tests++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
    end
  endtask

  task automatic test_zero_reg();
    sb_t e;
    logic [31:0] got;
    drive(1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 5'd0, 32'h0);
    set_ra(5'd0, 5'd0, 5'd0);
    push("zero_hard", 0, 32'h0);
    push("zero_plain", 3, 32'hFFFF_FFFF);
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = observe(e.port); n_tests++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
    end
    for (int a = 1; a < 32; a++) begin
      set_ra(5'(a), 5'(32 - a), 5'(a));
      push_all("zero_others");
      #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = observe(e.port); n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
      end
    end
  endtask

  task automatic test_reset_priority();
    sb_t e;
    logic [31:0] got;
    drive(1'b1, 5'd3, 32'h0000_0033);
    step();
    drive(1'b1, 5'd3, 32'h0000_00AA);
    RST = 1'b1;
    set_ra(5'd3, 5'd3, 5'd3);
    push("prio_pre_old", 0, 32'h0000_0033);
    push_all("prio_pre");
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = observe(e.port); n_tests++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
    end
    step();
    RST = 1'b0;
    drive(1'b0, 5'd0, 32'h0);
    push("prio_r3", 0, 32'h0);
    push("prio_r3_rv", 3, RV1);
    push_all("prio_post");
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = observe(e.port); n_tests++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
    end
  endtask

  task automatic test_read_during_write();
    sb_t e;
    logic [31:0] got;
    drive(1'b1, 5'd4, 32'h0000_0001);
    step();
    drive(1'b1, 5'd4, 32'h0000_0002);
    set_ra(5'd4, 5'd5, 5'd4);
`ifdef REG_FILE_WR_BYPASS_EN
    push("rdw_pre", 0, 32'h0000_0002);
    push("rdw_pre_dd", 5, 32'h0000_0002);
`else
    push("rdw_pre", 0, 32'h0000_0001);
    push("rdw_pre_dd", 5, 32'h0000_0001);
`endif
    push_all("rdw_pre_all");
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = observe(e.port); n_tests++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
    end
    step();
    drive(1'b0, 5'd0, 32'h0);
    push("rdw_post", 0, 32'h0000_0002);
    push("rdw_post_z0", 3, 32'h0000_0002);
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = observe(e.port); n_tests++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
    end
  endtask

  task automatic test_we_low_sweep();
    sb_t e;
    logic [31:0] got;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101);
      step();
    end
    drive(1'b0, 5'd7, 32'h0);
    step();
    set_ra(5'd7, 5'd7, 5'd7);
    push("we_low_r7", 0, 32'h0707_0707);
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = observe(e.port); n_tests++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
    end
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a), 5'(31 - a), 5'(a));
      push("sweep_rd1", 0, 32'(a) * 32'h0101_0101);
      push("sweep_rd2", 1, 32'(31 - a) * 32'h0101_0101);
      push("sweep_dd", 2, 32'(a) * 32'h0101_0101);
      push_all("sweep_model");
      #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = observe(e.port); n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, got, e.exp); end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 5'd0, 32'h0);
    set_ra(5'd0, 5'd0, 5'd0);
    step();
    RST = 1'b0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_reset_priority();
    test_read_during_write();
    test_we_low_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
